pair_logic_debounced: RTL and testbench



---
 rtl/pair_logic_debounced_if.sv | 21 ++
 rtl/pair_logic_debounced.sv | 103 ++++++++++
 tb/tb_pair_logic_debounced.sv | 169 ++++++++++++++++
 3 files changed

// File: rtl/pair_logic_debounced_if.sv
// Bundle between the board pins and pair_logic_debounced: raw switches and mode in,
// debounced levels, combined result and change pulse out.
interface pair_logic_debounced_if #(
  parameter int N_PAIRS = 2
);
  logic [2*N_PAIRS-1:0] in_raw;
  logic [1:0]           mode;
  logic [2*N_PAIRS-1:0] in_stable;
  logic                 result;
  logic                 changed;

  modport master (
    output in_raw, mode,
    input  in_stable, result, changed
  );

  modport slave (
    input  in_raw, mode,
    output in_stable, result, changed
  );
endinterface

// File: rtl/pair_logic_debounced.sv
// Synchronises and debounces 2*N_PAIRS raw switch inputs, then combines them pair-wise
// under a run-time mode into a registered result with a one-cycle change pulse.
module pair_logic_debounced #(
  parameter int N_PAIRS         = 2,
  parameter int DEBOUNCE_CYCLES = 50000,
  parameter int CNT_W           = 16
) (
  input  logic                clk,
  input  logic                rst_n,
  pair_logic_debounced_if.slave bus
);

  localparam int W = 2 * N_PAIRS;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);

  typedef enum logic [1:0] {
    MODE_OR_OF_ANDS  = 2'b00,
    MODE_AND_OF_ORS  = 2'b01,
    MODE_XOR_OF_ANDS = 2'b10,
    MODE_HOLD        = 2'b11
  } mode_e;

  logic [W-1:0]       s1_q, s2_q;
  logic [W-1:0]       stable_q, stable_d;
  logic [CNT_W-1:0]   cnt_q [W];
  logic [CNT_W-1:0]   cnt_d [W];
  logic               result_q, result_d;
  logic               changed_q, changed_d;
  logic [N_PAIRS-1:0] and_terms, or_terms;
  logic               f;
  mode_e              mode;

  assign mode = mode_e'(bus.mode);

  // NOTE: every variable written here gets a default first, so no path can infer a latch.
  always_comb begin
    stable_d = stable_q;
    for (int i = 0; i < W; i++) begin
      cnt_d[i] = '0;
      // The counter only runs while the synchronised level disagrees with the accepted one.
      if (s2_q[i] != stable_q[i]) begin
        if (cnt_q[i] == CNT_LAST) begin
          stable_d[i] = s2_q[i];
        end else begin
          cnt_d[i] = cnt_q[i] + CNT_W'(1);
        end
      end
    end
  end

  always_comb begin
    and_terms = '0;
    or_terms  = '0;
    for (int k = 0; k < N_PAIRS; k++) begin
      and_terms[k] = stable_q[2*k+1] & stable_q[2*k];
      or_terms[k]  = stable_q[2*k+1] | stable_q[2*k];
    end
  end

  always_comb begin
    f = 1'b0;
    unique case (mode)
      MODE_OR_OF_ANDS:  f = |and_terms;
      MODE_AND_OF_ORS:  f = &or_terms;
      MODE_XOR_OF_ANDS: f = ^and_terms;
      MODE_HOLD:        f = result_q;
    endcase
  end

  always_comb begin
    result_d  = result_q;
    changed_d = 1'b0;
    if (mode != MODE_HOLD) begin
      result_d  = f;
      changed_d = (f != result_q);
    end
  end

  // NOTE: state uses non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s1_q      <= '0;
      s2_q      <= '0;
      stable_q  <= '0;
      result_q  <= 1'b0;
      changed_q <= 1'b0;
      // NOTE: the counter array is reset too, so a reset mid-debounce discards partial counts.
      for (int i = 0; i < W; i++) cnt_q[i] <= '0;
    end else begin
      s1_q      <= bus.in_raw;
      s2_q      <= s1_q;
      stable_q  <= stable_d;
      result_q  <= result_d;
      changed_q <= changed_d;
      for (int i = 0; i < W; i++) cnt_q[i] <= cnt_d[i];
    end
  end

  assign bus.in_stable = stable_q;
  assign bus.result    = result_q;
  assign bus.changed   = changed_q;

endmodule

// File: tb/tb_pair_logic_debounced.sv
// Directed bench for pair_logic_debounced with N_PAIRS=2, DEBOUNCE_CYCLES=4, CNT_W=3.
module tb_pair_logic_debounced;

  logic clk;
  logic rst_n;
  int   n_checks;
  int   n_pass;
  int   pulse_cnt;
  int   pulse_mark;

  pair_logic_debounced_if #(.N_PAIRS(2)) bus ();

  pair_logic_debounced #(
    .N_PAIRS(2),
    .DEBOUNCE_CYCLES(4),
    .CNT_W(3)
  ) dut (
    .clk  (clk),
    .rst_n(rst_n),
    .bus  (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Counts every changed pulse so quiet stretches can be proven quiet.
  always @(negedge clk) if (bus.changed === 1'b1) pulse_cnt++;

  initial begin
    #200000;
    $display("FAIL timeout: simulation still running at %0t, required finish earlier", $time);
    $fatal(1, "timeout");
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
  endtask

  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  initial begin
    n_checks  = 0;
    n_pass    = 0;
    pulse_cnt = 0;
    rst_n       = 1'b0;
    bus.in_raw  = 4'b0000;
    bus.mode    = 2'b00;

    // Reset state and idle with zero inputs.
    #12;
    check("rst_stable", 32'(bus.in_stable), 32'h0);
    check("rst_result", 32'(bus.result), 32'h0);
    check("rst_changed", 32'(bus.changed), 32'h0);
    @(posedge clk); #5 rst_n = 1'b1;
    tick(8);
    check("idle_stable", 32'(bus.in_stable), 32'h0);
    check("idle_result", 32'(bus.result), 32'h0);

    // 0000 -> 0011 under OR-of-ANDs; sampling edge is the first tick.
    bus.in_raw = 4'b0011;
    tick(5);
    check("lat_early", 32'(bus.in_stable), 32'h0);
    tick(1);
    check("lat_stable", 32'(bus.in_stable), 32'h3);
    check("lat_result_lag", 32'(bus.result), 32'h0);
    tick(1);
    check("t2_result", 32'(bus.result), 32'h1);
    check("t2_changed", 32'(bus.changed), 32'h1);
    tick(1);
    check("t2_pulse_end", 32'(bus.changed), 32'h0);

    // Three-cycle glitch on bit2 must be rejected.
    pulse_mark = pulse_cnt;
    bus.in_raw = 4'b0111;
    tick(3);
    bus.in_raw = 4'b0011;
    tick(10);
    check("glitch_stable", 32'(bus.in_stable), 32'h3);
    check("glitch_result", 32'(bus.result), 32'h1);
    // Held bit2 is accepted, but f stays 1 so no pulse.
    bus.in_raw = 4'b0111;
    tick(5);
    check("bit2_early", 32'(bus.in_stable), 32'h3);
    tick(1);
    check("bit2_stable", 32'(bus.in_stable), 32'h7);
    tick(2);
    check("bit2_result", 32'(bus.result), 32'h1);
    check("bit2_no_pulse", 32'(pulse_cnt), 32'(pulse_mark));

    // All ones: mode changes alone toggle the result.
    bus.in_raw = 4'b1111;
    tick(6);
    check("ones_stable", 32'(bus.in_stable), 32'hf);
    tick(1);
    check("ones_or_result", 32'(bus.result), 32'h1);
    check("ones_or_changed", 32'(bus.changed), 32'h0);
    bus.mode = 2'b10;
    tick(1);
    check("xor_result", 32'(bus.result), 32'h0);
    check("xor_changed", 32'(bus.changed), 32'h1);
    tick(1);
    check("xor_pulse_end", 32'(bus.changed), 32'h0);
    bus.mode = 2'b01;
    tick(1);
    check("andor_result", 32'(bus.result), 32'h1);
    check("andor_changed", 32'(bus.changed), 32'h1);

    // Hold mode freezes the result while inputs drop to zero.
    bus.mode = 2'b11;
    tick(1);
    pulse_mark = pulse_cnt;
    check("hold_enter", 32'(bus.result), 32'h1);
    bus.in_raw = 4'b0000;
    tick(6);
    check("hold_stable", 32'(bus.in_stable), 32'h0);
    check("hold_result", 32'(bus.result), 32'h1);
    check("hold_no_pulse", 32'(pulse_cnt), 32'(pulse_mark));
    bus.mode = 2'b00;
    tick(1);
    check("unhold_result", 32'(bus.result), 32'h0);
    check("unhold_changed", 32'(bus.changed), 32'h1);
    tick(1);
    check("unhold_pulse_end", 32'(bus.changed), 32'h0);
    check("unhold_one_pulse", 32'(pulse_cnt), 32'(pulse_mark + 1));

    // Upper pair only: XOR-of-ANDs gives 1, AND-of-ORs gives 0, OR-of-ANDs gives 1.
    bus.mode   = 2'b10;
    bus.in_raw = 4'b1100;
    tick(6);
    check("hi_stable", 32'(bus.in_stable), 32'hc);
    tick(1);
    check("hi_xor_result", 32'(bus.result), 32'h1);
    check("hi_xor_changed", 32'(bus.changed), 32'h1);
    bus.mode = 2'b01;
    tick(1);
    check("hi_andor_result", 32'(bus.result), 32'h0);
    check("hi_andor_changed", 32'(bus.changed), 32'h1);
    bus.mode = 2'b00;
    tick(1);
    check("hi_or_result", 32'(bus.result), 32'h1);

    // Reset mid-debounce, asserted between edges with outputs nonzero.
    bus.in_raw = 4'b0011;
    tick(4);
    check("mid_stable", 32'(bus.in_stable), 32'hc);
    #3 rst_n = 1'b0;
    #1;
    check("async_stable", 32'(bus.in_stable), 32'h0);
    check("async_result", 32'(bus.result), 32'h0);
    check("async_changed", 32'(bus.changed), 32'h0);
    @(posedge clk); #5 rst_n = 1'b1;
    tick(5);
    check("post_rst_early", 32'(bus.in_stable), 32'h0);
    tick(1);
    check("post_rst_stable", 32'(bus.in_stable), 32'h3);
    tick(1);
    check("post_rst_result", 32'(bus.result), 32'h1);
    check("post_rst_changed", 32'(bus.changed), 32'h1);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
